// File: rtl/btb_pkg.sv
// Shared types for the fetch branch target buffer: table entry layout,
// 2-bit direction counter encoding and the counter saturation helpers.
package btb_pkg;

  // Entry fields are sized for the widest supported PC; narrower builds zero-extend.
  localparam int BtbMaxWidth = 64;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                   valid;
    logic [BtbMaxWidth-1:0] tag;
    logic [BtbMaxWidth-1:0] target;
    ctr_e                   ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_next(ctr_e ctr, logic taken);
    ctr_e nxt;
    nxt = ctr;
    case (ctr)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      default:   nxt = taken ? STRONG_T : WEAK_T;
    endcase
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc32(logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/btb_stats.sv
// Bank of saturating 32-bit event counters used by fetch_btb when
// PRED_STATS_EN is defined.
import btb_pkg::*;

module btb_stats #(
  parameter int NumCounters = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NumCounters-1:0]      inc,
  output logic [NumCounters-1:0][31:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        if (inc[i]) count[i] <= sat_inc32(count[i]);
      end
    end
  end

endmodule

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters; one-cycle
// lookup, trained by resolution updates. Optional statistics under PRED_STATS_EN.
import btb_pkg::*;

module fetch_btb #(
  parameter int WordSize = 32,
  parameter int Entries  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                lookup_valid,
  input  logic [WordSize-1:0] lookup_pc,
  input  logic                flush,
  output logic                pred_valid,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_pc,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [WordSize-1:0] upd_target
`ifdef PRED_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_allocs
`endif
);

  localparam int IdxBits = $clog2(Entries);
  localparam int TagBits = WordSize - IdxBits - 2;

  btb_entry_t           table_q [Entries];
  logic [IdxBits-1:0]   lk_idx;
  logic [IdxBits-1:0]   up_idx;
  logic [TagBits-1:0]   lk_tag;
  logic [TagBits-1:0]   up_tag;
  btb_entry_t           lk_entry;
  btb_entry_t           up_entry;
  logic                 lk_hit;
  logic                 lk_taken;
  logic                 up_hit;
  logic                 alloc;
  logic                 upd_pc_unused;

  assign lk_idx        = lookup_pc[IdxBits+1:2];
  assign lk_tag        = lookup_pc[WordSize-1:IdxBits+2];
  assign up_idx        = upd_pc[IdxBits+1:2];
  assign up_tag        = upd_pc[WordSize-1:IdxBits+2];
  assign upd_pc_unused = ^upd_pc[1:0];

  // Both ports read the table as it stood before this edge's update.
  always_comb begin
    lk_entry = table_q[lk_idx];
    up_entry = table_q[up_idx];
    lk_hit   = lk_entry.valid && (lk_entry.tag == BtbMaxWidth'(lk_tag));
    lk_taken = lk_hit && (lk_entry.ctr inside {WEAK_T, STRONG_T});
    up_hit   = up_entry.valid && (up_entry.tag == BtbMaxWidth'(up_tag));
    alloc    = upd_valid && !up_hit && upd_taken;
  end

  // Training: hits move the counter (and retarget on taken), taken misses
  // claim the slot. Flush does not suppress training.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < Entries; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        table_q[up_idx].ctr <= ctr_next(up_entry.ctr, upd_taken);
        if (upd_taken) table_q[up_idx].target <= BtbMaxWidth'(upd_target);
      end else if (alloc) begin
        table_q[up_idx] <= '{valid: 1'b1, tag: BtbMaxWidth'(up_tag),
                             target: BtbMaxWidth'(upd_target), ctr: WEAK_T};
      end
    end
  end

  // pred_pc keeps its last value whenever no new prediction is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
      pred_pc    <= '0;
    end else if (flush || !lookup_valid) begin
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= 1'b1;
      pred_hit   <= lk_hit;
      pred_taken <= lk_taken;
      pred_pc    <= lk_taken ? WordSize'(lk_entry.target) : lookup_pc + WordSize'(4);
    end
  end

`ifdef PRED_STATS_EN
  logic [2:0][31:0] stat_count;

  btb_stats #(
    .NumCounters(3)
  ) u_stats (
    .clk   (clk),
    .rstn  (rstn),
    .inc   ({alloc, pred_hit, lookup_valid}),
    .count (stat_count)
  );

  assign stat_lookups = stat_count[0];
  assign stat_hits    = stat_count[1];
  assign stat_allocs  = stat_count[2];
`endif

endmodule

// File: tb/tb_fetch_btb.sv
// Scoreboard bench for fetch_btb: directed scenarios then random traffic,
// checked against an array-based model of the prediction table.
module tb_fetch_btb;

  logic        clk;
  logic        rstn;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        flush;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
`ifdef PRED_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_allocs;
`endif

  fetch_btb #(
    .WordSize(32),
    .Entries (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .flush        (flush),
    .pred_valid   (pred_valid),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_pc      (pred_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target)
`ifdef PRED_STATS_EN
    ,
    .stat_lookups (stat_lookups),
    .stat_hits    (stat_hits),
    .stat_allocs  (stat_allocs)
`endif
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q [$];
  int          n_compared;
  int          n_mismatched;

  // Reference table: one slot per index, counter held as a plain integer 0..3.
  logic        m_valid  [16];
  logic [25:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int          m_lookups;
  int          m_hits;
  int          m_allocs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [33:0] actual, input logic [33:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_ctr[i]    = 1;
    end
    m_lookups = 0;
    m_hits    = 0;
    m_allocs  = 0;
  endtask

  // Drives one cycle of inputs and advances the model exactly as the spec
  // describes: predict from the old table, then train.
  task automatic apply_stimulus(input logic lv, input logic [31:0] lpc, input logic fl,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt);
    int   li;
    int   ui;
    exp_t e;
    logic uhit;
    @(negedge clk);
    lookup_valid = lv;
    lookup_pc    = lpc;
    flush        = fl;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_taken    = ut;
    upd_target   = utgt;
    li = int'(lpc[5:2]);
    ui = int'(upc[5:2]);
    if (lv) m_lookups++;
    if (lv && !fl) begin
      e.hit   = m_valid[li] && (m_tag[li] == lpc[31:6]);
      e.taken = e.hit && (m_ctr[li] >= 2);
      e.pc    = e.taken ? m_target[li] : lpc + 32'd4;
      if (e.hit) m_hits++;
      exp_q.push_back(e);
    end
    if (uv) begin
      uhit = m_valid[ui] && (m_tag[ui] == upc[31:6]);
      if (uhit) begin
        m_ctr[ui] = ut ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                       : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
        if (ut) m_target[ui] = utgt;
      end else if (ut) begin
        m_valid[ui]  = 1'b1;
        m_tag[ui]    = upc[31:6];
        m_target[ui] = utgt;
        m_ctr[ui]    = 2;
        m_allocs++;
      end
    end
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    apply_stimulus(1'b1, pc, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, pc, taken, tgt);
  endtask

  task automatic do_idle();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: every presented prediction is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        if (pred_valid) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_pred", {1'b1, 1'b0, 32'h0}, {1'b0, 1'b0, 32'h0});
          end else begin
            e = exp_q.pop_front();
            check_output("prediction", {pred_hit, pred_taken, pred_pc}, {e.hit, e.taken, e.pc});
          end
        end else begin
          check_output("idle_flags", {32'h0, pred_hit, pred_taken}, 34'h0);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    n_compared   = 0;
    n_mismatched = 0;
    model_clear();
    rstn         = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    flush        = 1'b0;
    upd_valid    = 1'b0;
    upd_pc       = '0;
    upd_taken    = 1'b0;
    upd_target   = '0;
    #1;
    check_output("reset_outputs", {pred_valid, pred_hit, pred_pc}, 34'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Cold lookup, allocate, then retrain down through the counter range.
    do_lookup(32'h100);
    do_update(32'h100, 1'b1, 32'h200);
    do_lookup(32'h100);
    do_update(32'h100, 1'b0, 32'h0);
    do_update(32'h100, 1'b0, 32'h0);
    do_lookup(32'h100);
    do_update(32'h100, 1'b0, 32'h0);
    do_update(32'h100, 1'b1, 32'h280);
    do_lookup(32'h100);

    // Same index, different tag evicts the old branch.
    do_update(32'h140, 1'b1, 32'h600);
    do_lookup(32'h100);
    do_lookup(32'h140);

    // Lookup and allocation in the same cycle see the pre-update table.
    apply_stimulus(1'b1, 32'h300, 1'b0, 1'b1, 32'h300, 1'b1, 32'h700);
    do_lookup(32'h300);

    // Flush kills the prediction but still trains.
    apply_stimulus(1'b1, 32'h300, 1'b1, 1'b1, 32'h300, 1'b1, 32'h780);
    do_lookup(32'h300);

    // Fall-through address wraps at the top of the address space.
    do_lookup(32'hFFFF_FFFC);
    do_idle();

    // Asynchronous reset drops the current and pending prediction at once.
    do_lookup(32'h300);
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h300;
    #2;
    rstn = 1'b0;
    #1;
    check_output("async_reset", {pred_valid, pred_taken, pred_pc}, 34'h0);
    model_clear();
    @(negedge clk);
    lookup_valid = 1'b0;
    rstn = 1'b1;
    do_lookup(32'h300);

    // Random traffic over a small address pool so entries collide and train.
    for (int n = 0; n < 500; n++) begin
      pc_a = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      pc_b = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      if ($urandom_range(0, 15) == 0) pc_a = pc_a | 32'hFFFF_FF00;
      if ($urandom_range(0, 15) == 0) pc_b = pc_b | 32'hFFFF_FF00;
      apply_stimulus($urandom_range(0, 3) != 0, pc_a, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 1) == 1, pc_b, $urandom_range(0, 2) != 0,
                     $urandom & 32'hFFFF_FFFC);
    end

    repeat (3) do_idle();
    check_output("drained", 34'(exp_q.size()), 34'h0);
`ifdef PRED_STATS_EN
    check_output("stat_lookups", 34'(stat_lookups), 34'(m_lookups));
    check_output("stat_hits", 34'(stat_hits), 34'(m_hits));
    check_output("stat_allocs", 34'(stat_allocs), 34'(m_allocs));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
